// File: rtl/vga_text_op_engine.sv
// Bulk CLEAR / SCROLL_UP / FILL_ROW engine for the text character and colour maps.
// Every map access is issued only while the display is blanked.
module vga_text_op_engine #(
   parameter int COLS   = 80,
   parameter int ROWS   = 30,
   parameter int ADDR_W = 12,
   parameter int CH_W   = 8,
   parameter int ROW_W  = 5
) (
   input  logic              factor_clk_i,
   input  logic              factor_arstn_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [ROW_W-1:0]  cmd_row_i,
   input  logic [CH_W-1:0]   fill_ch_i,
   input  logic [7:0]        fill_col_i,
   input  logic              blank_i,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [CH_W-1:0]   mem_ch_wdata_o,
   output logic [7:0]        mem_col_wdata_o,
   input  logic [CH_W-1:0]   mem_ch_rdata_i,
   input  logic [7:0]        mem_col_rdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [2:0] {IDLE, FILL, RD, RDW, WR, DONE} state_t;

   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(COLS*ROWS-1);
   localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'(COLS*(ROWS-1)-1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] ptr, ptr_nx;
   logic [ADDR_W-1:0] last, last_nx;
   logic [CH_W-1:0]   fch, fch_nx, hch, hch_nx;
   logic [7:0]        fcol, fcol_nx, hcol, hcol_nx;
   logic              err, err_nx;
   logic [ADDR_W-1:0] row_base;

   assign row_base = ADDR_W'(cmd_row_i) * COLS_A;

   always_ff @(posedge factor_clk_i or negedge factor_arstn_i) begin
      if (!factor_arstn_i) begin
         state <= IDLE;
         ptr   <= '0;
         last  <= '0;
         fch   <= '0;
         fcol  <= '0;
         hch   <= '0;
         hcol  <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         last  <= last_nx;
         fch   <= fch_nx;
         fcol  <= fcol_nx;
         hch   <= hch_nx;
         hcol  <= hcol_nx;
         err   <= err_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      ptr_nx          = ptr;
      last_nx         = last;
      fch_nx          = fch;
      fcol_nx         = fcol;
      hch_nx          = hch;
      hcol_nx         = hcol;
      err_nx          = err;
      cmd_ready_o     = 1'b0;
      busy_o          = 1'b0;
      done_o          = 1'b0;
      err_o           = 1'b0;
      mem_en_o        = 1'b0;
      mem_we_o        = 1'b0;
      mem_addr_o      = '0;
      mem_ch_wdata_o  = '0;
      mem_col_wdata_o = '0;
      unique case (state)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               fch_nx  = fill_ch_i;
               fcol_nx = fill_col_i;
               err_nx  = 1'b0;
               ptr_nx  = '0;
               unique case (cmd_op_i)
                  2'b00: begin
                     last_nx  = LAST_A;
                     state_nx = FILL;
                  end
                  2'b01: state_nx = RD;
                  2'b10: begin
                     if (int'(cmd_row_i) >= ROWS) begin
                        err_nx   = 1'b1;
                        state_nx = DONE;
                     end else begin
                        ptr_nx   = row_base;
                        last_nx  = row_base + COLS_A - 1'b1;
                        state_nx = FILL;
                     end
                  end
                  default: begin
                     err_nx   = 1'b1;
                     state_nx = DONE;
                  end
               endcase
            end
         end
         FILL: begin
            busy_o = 1'b1;
            if (blank_i) begin
               mem_en_o        = 1'b1;
               mem_we_o        = 1'b1;
               mem_addr_o      = ptr;
               mem_ch_wdata_o  = fch;
               mem_col_wdata_o = fcol;
               if (ptr == last) state_nx = DONE;
               else ptr_nx = ptr + 1'b1;
            end
         end
         RD: begin
            busy_o = 1'b1;
            if (blank_i) begin
               mem_en_o   = 1'b1;
               mem_addr_o = ptr + COLS_A;
               state_nx   = RDW;
            end
         end
         // read already issued: capture even if blanking just ended
         RDW: begin
            busy_o   = 1'b1;
            hch_nx   = mem_ch_rdata_i;
            hcol_nx  = mem_col_rdata_i;
            state_nx = WR;
         end
         WR: begin
            busy_o = 1'b1;
            if (blank_i) begin
               mem_en_o        = 1'b1;
               mem_we_o        = 1'b1;
               mem_addr_o      = ptr;
               mem_ch_wdata_o  = hch;
               mem_col_wdata_o = hcol;
               ptr_nx          = ptr + 1'b1;
               if (ptr == SCR_LAST) begin
                  last_nx  = LAST_A;
                  state_nx = FILL;
               end else begin
                  state_nx = RD;
               end
            end
         end
         DONE: begin
            done_o   = 1'b1;
            err_o    = err;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_vga_text_op_engine.sv
// Scoreboard bench for vga_text_op_engine with a 1-cycle-latency map model.
module tb_vga_text_op_engine;

   typedef struct packed {
      logic [11:0] a;
      logic [7:0]  ch;
      logic [7:0]  col;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_row = '0;
   logic [7:0]  fill_ch = '0;
   logic [7:0]  fill_col = '0;
   logic        blank = 1'b1;
   logic        mem_en, mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_ch_wdata, mem_col_wdata;
   logic [7:0]  rch = '0, rcol = '0;
   logic        busy, done, err;

   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;
   int en_cnt = 0;
   int blank_mode = 0;
   int line_cnt = 0;
   logic preload = 1'b0;

   logic [7:0] mch [4096];
   logic [7:0] mcol [4096];
   logic [7:0] snap_ch [2400];
   logic [7:0] snap_col [2400];
   wr_t sb[$];

   vga_text_op_engine dut (
      .factor_clk_i(clk),
      .factor_arstn_i(rst_n),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op),
      .cmd_row_i(cmd_row),
      .fill_ch_i(fill_ch),
      .fill_col_i(fill_col),
      .blank_i(blank),
      .mem_en_o(mem_en),
      .mem_we_o(mem_we),
      .mem_addr_o(mem_addr),
      .mem_ch_wdata_o(mem_ch_wdata),
      .mem_col_wdata_o(mem_col_wdata),
      .mem_ch_rdata_i(rch),
      .mem_col_rdata_i(rcol),
      .busy_o(busy),
      .done_o(done),
      .err_o(err)
   );

   always #5 clk = ~clk;

   // map model: ch = addr[7:0], col = ~addr[7:0] on preload
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 4096; i++) begin
            mch[i]  <= i[7:0];
            mcol[i] <= ~i[7:0];
         end
      end else if (mem_en && mem_we) begin
         mch[mem_addr]  <= mem_ch_wdata;
         mcol[mem_addr] <= mem_col_wdata;
      end
      if (mem_en && !mem_we) begin
         rch  <= mch[mem_addr];
         rcol <= mcol[mem_addr];
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (blank_mode == 1) begin
            blank = (line_cnt < 160);
            line_cnt = (line_cnt == 799) ? 0 : line_cnt + 1;
         end else if (blank_mode == 0) begin
            blank = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (!blank) begin
         checks++;
         if (mem_en) begin
            failures++;
            $display("FAIL own: mem_en=%b we=%b while blank=0", mem_en, mem_we);
         end
      end
      if (mem_en) en_cnt++;
      if (mem_en && mem_we) begin
         checks++;
         wr_cnt++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL extra_write: addr=%0d ch=%h col=%h, none expected",
                     mem_addr, mem_ch_wdata, mem_col_wdata);
         end else begin
            e = sb.pop_front();
            if ({mem_addr, mem_ch_wdata, mem_col_wdata} !== e) begin
               failures++;
               $display("FAIL write: got a=%0d ch=%h col=%h need a=%0d ch=%h col=%h",
                        mem_addr, mem_ch_wdata, mem_col_wdata, e.a, e.ch, e.col);
            end
         end
      end
   end

   task automatic push(input int a, input logic [7:0] ch, input logic [7:0] col);
      wr_t e;
      e.a = a[11:0];
      e.ch = ch;
      e.col = col;
      sb.push_back(e);
   endtask

   task automatic send(input logic [1:0] op, input logic [4:0] row,
                       input logic [7:0] ch, input logic [7:0] col);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_row = row;
      fill_ch = ch;
      fill_col = col;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n, output logic e);
      n = 0;
      e = 1'b0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (done) begin
            n = i;
            e = err;
            break;
         end
      end
   endtask

   task automatic do_preload();
      @(posedge clk);
      #1;
      preload = 1'b1;
      @(posedge clk);
      #1;
      preload = 1'b0;
   endtask

   task automatic push_scroll(input logic [7:0] ch, input logic [7:0] col);
      for (int a = 0; a < 2320; a++) push(a, mch[a+80], mcol[a+80]);
      for (int a = 2320; a < 2400; a++) push(a, ch, col);
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({cmd_ready, busy, done, err, mem_en, mem_we} !== 6'b100000 ||
          mem_addr !== 12'd0) begin
         failures++;
         $display("FAIL reset_vals: rdy/busy/done/err/en/we=%b addr=%0d need 100000 0",
                  {cmd_ready, busy, done, err, mem_en, mem_we}, mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_clear();
      int n;
      logic e;
      for (int a = 0; a < 2400; a++) push(a, 8'h20, 8'h0F);
      send(2'b00, 5'd0, 8'h20, 8'h0F);
      wait_done(3000, n, e);
      checks++;
      if (n !== 2401 || e !== 1'b0) begin
         failures++;
         $display("FAIL clear_latency: done at %0d err=%b need 2401 err=0", n, e);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL clear_writes: %0d writes missing need 0", sb.size());
      end
   endtask

   task automatic test_fill_row();
      int n;
      logic e;
      for (int a = 2320; a < 2400; a++) push(a, 8'h41, 8'hA5);
      send(2'b10, 5'd29, 8'h41, 8'hA5);
      cmd_valid = 1'b1;
      cmd_op = 2'b00;
      repeat (5) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_done(200, n, e);
      checks++;
      if (n !== 76 || e !== 1'b0) begin
         failures++;
         $display("FAIL fill_row_latency: done at %0d+5 err=%b need 81 err=0", n, e);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || sb.size() != 0) begin
         failures++;
         $display("FAIL busy_ignore: busy=%b rdy=%b pending=%0d need 0 1 0",
                  busy, cmd_ready, sb.size());
      end
   endtask

   task automatic test_errors();
      int n, base;
      logic e;
      base = en_cnt;
      send(2'b10, 5'd30, 8'h11, 8'h22);
      wait_done(2, n, e);
      checks++;
      if (n == 0 || e !== 1'b1) begin
         failures++;
         $display("FAIL err_row: done at %0d err=%b need <=2 err=1", n, e);
      end
      send(2'b11, 5'd0, 8'h11, 8'h22);
      wait_done(2, n, e);
      checks++;
      if (n == 0 || e !== 1'b1) begin
         failures++;
         $display("FAIL err_op: done at %0d err=%b need <=2 err=1", n, e);
      end
      checks++;
      if (en_cnt != base) begin
         failures++;
         $display("FAIL err_access: mem_en cycles=%0d need 0", en_cnt - base);
      end
   endtask

   task automatic test_scroll();
      int n;
      logic e;
      do_preload();
      push_scroll(8'h2E, 8'h07);
      send(2'b01, 5'd0, 8'h2E, 8'h07);
      wait_done(8000, n, e);
      checks++;
      if (n !== 7041 || e !== 1'b0) begin
         failures++;
         $display("FAIL scroll_latency: done at %0d err=%b need 7041 err=0", n, e);
      end
      @(negedge clk);
      checks++;
      if (mch[0] !== 8'd80 || mcol[0] !== 8'hAF || mch[2319] !== 8'h5F ||
          mch[2320] !== 8'h2E || mcol[2399] !== 8'h07) begin
         failures++;
         $display("FAIL scroll_map: m0=%h/%h m2319=%h m2320=%h c2399=%h need 50/af 5f 2e 07",
                  mch[0], mcol[0], mch[2319], mch[2320], mcol[2399]);
      end
      for (int a = 0; a < 2400; a++) begin
         snap_ch[a] = mch[a];
         snap_col[a] = mcol[a];
      end
   endtask

   task automatic test_scroll_toggle();
      int n, bad;
      logic e;
      do_preload();
      push_scroll(8'h2E, 8'h07);
      line_cnt = 0;
      blank_mode = 1;
      send(2'b01, 5'd0, 8'h2E, 8'h07);
      wait_done(45000, n, e);
      blank_mode = 0;
      checks++;
      if (n == 0 || sb.size() != 0) begin
         failures++;
         $display("FAIL toggle_done: done at %0d pending=%0d need done, 0", n, sb.size());
      end
      @(negedge clk);
      bad = 0;
      for (int a = 0; a < 2400; a++)
         if (mch[a] !== snap_ch[a] || mcol[a] !== snap_col[a]) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL toggle_map: %0d cells differ need 0", bad);
      end
   endtask

   task automatic test_rdw_drop();
      int n;
      logic e;
      do_preload();
      push_scroll(8'h5A, 8'h3C);
      blank_mode = 2;
      blank = 1'b1;
      send(2'b01, 5'd0, 8'h5A, 8'h3C);
      @(posedge clk);
      #1;
      blank = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      blank = 1'b1;
      blank_mode = 0;
      wait_done(8000, n, e);
      checks++;
      if (n == 0 || sb.size() != 0) begin
         failures++;
         $display("FAIL rdw_drop: done at %0d pending=%0d need done, 0", n, sb.size());
      end
      @(negedge clk);
      checks++;
      if (mch[0] !== 8'd80 || mcol[0] !== 8'hAF) begin
         failures++;
         $display("FAIL rdw_cell0: got %h/%h need 50/af", mch[0], mcol[0]);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n, base, guard;
      logic e;
      for (int a = 0; a < 2400; a++) push(a, 8'h00, 8'hF0);
      base = wr_cnt;
      send(2'b00, 5'd0, 8'h00, 8'hF0);
      guard = 0;
      while (wr_cnt - base < 1000 && guard < 1500) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (wr_cnt - base != 1000) begin
         failures++;
         $display("FAIL mid_clear_reach: writes=%0d need 1000", wr_cnt - base);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, busy, done, err, mem_en, mem_we} !== 6'b100000) begin
         failures++;
         $display("FAIL mid_reset_vals: rdy/busy/done/err/en/we=%b need 100000",
                  {cmd_ready, busy, done, err, mem_en, mem_we});
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int a = 0; a < 2400; a++) push(a, 8'h33, 8'h44);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op = 2'b00;
      fill_ch = 8'h33;
      fill_col = 8'h44;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_ready: got %b need 1", cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_done(3000, n, e);
      checks++;
      if (n !== 2401 || sb.size() != 0) begin
         failures++;
         $display("FAIL post_reset_clear: done at %0d pending=%0d need 2401 0",
                  n, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_fill_row();
      test_errors();
      test_scroll();
      test_scroll_toggle();
      test_rdw_drop();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
